// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone classic master bridge.
// Ports: clk/rst_i, rx byte stream in, tx status/data out, Wishbone master.
// Frame: cmd (A5 write / 5A read), 4 addr bytes, [4 data bytes], MSB first.
// Response: ACK_BYTE (then 4 read bytes for reads) or ERR_BYTE on abort.
// Optional macro UART_WB_MASTER_TIMEOUT_EN adds a bus-cycle timeout.

module uart_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ACK_BYTE       = 8'hAC,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic        busy
);

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_RDATA
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        wr_q, wr_d;
  // Set when the status byte must be followed by read data bytes.
  logic        more_q, more_d;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_BYTE, 16'(TIMEOUT_CYCLES)};
`endif

  logic rx_hs;
  logic tx_hs;

  assign rx_ready = (state_q == S_IDLE) ||
                    (state_q == S_ADDR) ||
                    (state_q == S_WDATA);
  assign tx_valid = (state_q == S_RESP) ||
                    (state_q == S_RDATA);
  assign busy     = (state_q != S_IDLE);

  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;

  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign sel_o   = sel_q;
  assign we_o    = we_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign tx_data = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    tx_d    = tx_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    wr_d    = wr_q;
    more_d  = more_q;
`ifdef UART_WB_MASTER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_hs) begin
          if (rx_data == CMD_WR) begin
            state_d = S_ADDR;
            wr_d    = 1'b1;
            cnt_d   = 2'd0;
          end else if (rx_data == CMD_RD) begin
            state_d = S_ADDR;
            wr_d    = 1'b0;
            cnt_d   = 2'd0;
          end
        end
      end
      S_ADDR: begin
        if (rx_hs) begin
          adr_d = {adr_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (wr_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = 4'hF;
`ifdef UART_WB_MASTER_TIMEOUT_EN
              tmo_d   = 16'd0;
`endif
            end
          end
        end
      end
      S_WDATA: begin
        if (rx_hs) begin
          dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'hF;
`ifdef UART_WB_MASTER_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
          end
        end
      end
      S_BUS: begin
        // ack_i wins over a timeout landing on the same cycle.
        if (ack_i) begin
          state_d = S_RESP;
          cnt_d   = 2'd0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          tx_d    = ACK_BYTE;
          more_d  = !wr_q;
          if (!wr_q) begin
            rdat_d = dat_i;
          end
`ifdef UART_WB_MASTER_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_RESP;
          cnt_d   = 2'd0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          tx_d    = ERR_BYTE;
          more_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
        if (tx_hs) begin
          cnt_d = 2'd0;
          if (more_q) begin
            state_d = S_RDATA;
            tx_d    = rdat_q[31:24];
            rdat_d  = {rdat_q[23:0], 8'h00};
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RDATA: begin
        if (tx_hs) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            tx_d   = rdat_q[31:24];
            rdat_d = {rdat_q[23:0], 8'h00};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rdat_q  <= 32'd0;
      tx_q    <= 8'd0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      wr_q    <= 1'b0;
      more_q  <= 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
      tmo_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      tx_q    <= tx_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      wr_q    <= wr_d;
      more_q  <= more_d;
`ifdef UART_WB_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
